// File: rtl/nibble_add_sched.sv
// Two-requester sequencer that time-shares one SLICE-bit adder to perform WIDTH-bit
// additions LSB-slice first, chaining the carry through a register.
module nibble_add_sched #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [SLICE-1:0] add_a,
  output logic [SLICE-1:0] add_b,
  output logic             add_cin,
  input  logic [SLICE-1:0] add_sum,
  input  logic             add_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout
);
  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  typedef struct packed {
    logic                       id;
    logic [N-1:0][SLICE-1:0]    a;
    logic [N-1:0][SLICE-1:0]    b;
  } op_t;

  state_t                  st;
  op_t                     op;
  logic                    ptr;
  logic [KW-1:0]           k;
  logic                    carry;
  logic [N-1:0][SLICE-1:0] res;
  logic                    idle, run, acc;

  // Round-robin pointer only breaks ties; a lone requester always wins.
  assign idle       = (st == IDLE) & ~reset;
  assign run        = (st == RUN);
  assign req0_ready = idle & req0_valid & (~req1_valid | ~ptr);
  assign req1_ready = idle & req1_valid & (~req0_valid |  ptr);
  assign acc        = req0_ready | req1_ready;

  assign add_a   = run ? op.a[k] : '0;
  assign add_b   = run ? op.b[k] : '0;
  assign add_cin = run & (k != '0) & carry;

  // Response fields are forced to zero outside RESP so partial sums never leak.
  assign rsp_valid = (st == RESP);
  assign rsp_sum   = rsp_valid ? res : '0;
  assign rsp_cout  = rsp_valid & carry;
  assign rsp_id    = rsp_valid & op.id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st    <= IDLE;
      op    <= '0;
      ptr   <= 1'b0;
      k     <= '0;
      carry <= 1'b0;
      res   <= '0;
    end else begin
      unique case (st)
        IDLE: if (acc) begin
          op.id <= req1_ready;
          op.a  <= req1_ready ? req1_a : req0_a;
          op.b  <= req1_ready ? req1_b : req0_b;
          ptr   <= req0_ready;
          k     <= '0;
          carry <= 1'b0;
          st    <= RUN;
        end
        RUN: begin
          res[k] <= add_sum;
          carry  <= add_cout;
          k      <= k + 1'b1;
          if (k == KW'(N - 1)) st <= RESP;
        end
        RESP: if (rsp_ready) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/nibble_add_sched.md
# nibble_add_sched

Sequencer and arbiter that shares one combinational SLICE-bit adder (a, b, cin → sumout, cout) between two requesters that need WIDTH-bit additions. A granted WIDTH-bit operation is split into WIDTH/SLICE slices issued LSB-first on consecutive cycles, with the carry chained through a register. The assembled sum and carry-out are returned on a response handshake. The block sits between the wide-datapath producers and the shared narrow adder, replacing per-requester full-width adders.

## Interface
- WIDTH, 16, operand and result width; must be an integer multiple of SLICE
- SLICE, 4, width of the shared adder; N = WIDTH/SLICE slices per operation

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  requester i has an operation pending
- req0_ready / req1_ready  out  1  requester i accepted on this edge when valid & ready
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands; sampled only at acceptance
- add_a, add_b  out  SLICE  slice operands to the shared adder
- add_cin  out  1  carry-in to the shared adder
- add_sum  in  SLICE  adder sum output (combinational, same cycle)
- add_cout  in  1  adder carry-out (combinational, same cycle)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes the result on valid & ready
- rsp_id  out  1  index of the requester that owns the result
- rsp_sum  out  WIDTH  WIDTH-bit sum, mod 2^WIDTH
- rsp_cout  out  1  carry-out of the top slice

## Operation
- The FSM has three states. IDLE → RUN on acceptance. RUN → RESP after slice N−1 is captured. RESP → IDLE on rsp_valid & rsp_ready.
- Arbitration happens only in IDLE and is combinational.
  - If exactly one valid is asserted, that requester gets ready=1.
  - If both are asserted, the requester selected by the round-robin pointer gets ready=1.
  - The losing requester's ready is 0. Outside IDLE, both readies are 0.
- Round-robin pointer: on acceptance of requester i, pointer ← 1−i. The pointer resets to 0, so req0 has priority first.
- On acceptance, the block latches A, B and the winner's id, clears slice index k and the carry register. Operands may change afterwards without effect.
- RUN, slice k (k = 0..N−1):
  - add_a = A[k·SLICE +: SLICE], add_b = B[k·SLICE +: SLICE].
  - add_cin = 0 for k=0; otherwise the carry register (add_cout captured in slice k−1).
  - At the edge, add_sum is written into result bits [k·SLICE +: SLICE], the carry register ← add_cout, and k ← k+1.
- In RESP:
  - rsp_sum is the assembled result, rsp_cout is the final carry, rsp_id is the latched id.
  - These outputs are held stable while rsp_ready = 0.
- add_a, add_b and add_cin are 0 whenever the state is not RUN.
- Reset, asynchronous at any time including mid-RUN or in RESP:
  - state = IDLE, pointer = 0, k = 0, carry = 0.
  - rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, rsp_id = 0.
  - add_a = add_b = add_cin = 0; both readies = 0.
  - Any in-flight operation is discarded and never responded to.

## Timing
- Edge E0 is the acceptance edge. Slices 0..N−1 are driven in the cycles after E0 and captured on edges E1..EN.
- rsp_valid rises in the cycle after EN. With N=4, that is 5 cycles after E0.
- If rsp_ready=1 on the first RESP cycle, the response is consumed at edge EN+1 and IDLE is re-entered. A new acceptance is possible at edge EN+2.
- Minimum issue interval is N+2 cycles per operation.
- A req_ready can be high in the same cycle its req_valid rises, because arbitration is combinational. There is no combinational path from rsp_ready to req_ready.
- The shared adder path is add_a/add_b/add_cin → add_sum/add_cout, which must settle within one clk period.

## Test plan
- Single op: req0 a=0x1234, b=0x0FFF → add_a sequence 4,3,2,1; rsp_sum=0x2233, rsp_cout=0, rsp_id=0; rsp_valid high 5 cycles after acceptance.
- Carry ripple: req1 a=0xFFFF, b=0x0001 → add_cin sequence 0,1,1,1; rsp_sum=0x0000, rsp_cout=1, rsp_id=1.
- Contention: after reset, both valid continuously with distinct operands → grants in order req0, req1, req0, req1. Each rsp_id matches, and each sum is correct.
- Backpressure: rsp_ready=0 for 3 cycles in RESP → rsp_valid, rsp_sum, rsp_id and rsp_cout stable; both req_ready=0. The result is consumed on the first cycle with rsp_ready=1.
- Reset mid-RUN: reset asserted during slice 2 of a req1 op → all outputs 0 immediately, and no response for that op ever appears. After release, with both valid, req0 is granted first.
- Lone requester: req1 valid back-to-back with req0 idle → req1 is accepted every N+2 cycles, and the pointer never blocks it.
